// File: rtl/p2p_pkg.sv
// Shared types and helpers for the pointwise-to-pointwise ping-pong buffer.
// Optional feature macro used by this block: P2P_RELU_EN (ReLU on the read path).
package p2p_pkg;

   localparam int unsigned P2P_DW    = 16;
   localparam int unsigned P2P_OCP   = 8;
   localparam int unsigned P2P_ICP   = 8;
   localparam int unsigned P2P_DEPTH = 32;
   localparam int unsigned WORD_W    = P2P_DW * P2P_OCP;

   typedef enum logic [0:0] {
      StIdle,
      StStream
   } state_e;

   // Signed add clamped to a dw-bit two's complement range.
   function automatic int sat_add(input int a, input int b, input int unsigned dw);
      int sum;
      int hi;
      int lo;
      sum = a + b;
      hi  = (1 << (dw - 1)) - 1;
      lo  = -hi - 1;
      if (sum > hi) return hi;
      if (sum < lo) return lo;
      return sum;
   endfunction

endpackage

// File: rtl/p2p_if.sv
// Downstream word stream of the p2p buffer: valid/ready plus data, channel base and last flag.
interface p2p_if #(
   parameter int unsigned WIDTH = p2p_pkg::WORD_W
);
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [7:0]       out_channel_sel;
   logic             out_last;

   modport master(output out_valid, output out_data, output out_channel_sel, output out_last,
                  input out_ready);
   modport slave(input out_valid, input out_data, input out_channel_sel, input out_last,
                 output out_ready);
endinterface

// File: rtl/p2p_bank.sv
// One bank of the ping-pong buffer: DEPTH words, overwrite or lane-wise saturating accumulate on
// write, combinational read.
module p2p_bank
   import p2p_pkg::*;
#(
   parameter int unsigned DEPTH      = P2P_DEPTH,
   parameter int unsigned DATA_WIDTH = P2P_DW,
   parameter int unsigned LANES      = P2P_OCP,
   localparam int unsigned AW        = $clog2(DEPTH),
   localparam int unsigned WW        = DATA_WIDTH * LANES
) (
   input  logic          clk,
   input  logic          we,
   input  logic          accum,
   input  logic [AW-1:0] waddr,
   input  logic [WW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [WW-1:0] rdata
);

   logic [WW-1:0] mem [DEPTH];
   logic [WW-1:0] cur;
   logic [WW-1:0] acc_word;

   // Read-modify-write resolves within the cycle so back-to-back partials to one word chain.
   always_comb begin
      cur      = mem[waddr];
      acc_word = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         acc_word[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(sat_add(
            int'($signed(cur[i*DATA_WIDTH +: DATA_WIDTH])),
            int'($signed(wdata[i*DATA_WIDTH +: DATA_WIDTH])),
            DATA_WIDTH));
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= accum ? acc_word : wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/p2p_buffer.sv
// Ping-pong buffer: accumulates pointwise partial sums into one bank while the other streams out.
// Define P2P_RELU_EN to clamp negative lanes to zero on the output word.
module p2p_buffer
   import p2p_pkg::*;
#(
   parameter int unsigned DATA_WIDTH             = P2P_DW,
   parameter int unsigned OUTCHANNEL_PARALLELISM = P2P_OCP,
   parameter int unsigned INCHANNEL_PARALLELISM  = P2P_ICP,
   parameter int unsigned DEPTH                  = P2P_DEPTH
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [7:0]                                   input_channel,
   input  logic [7:0]                                   output_channel,
   input  logic                                         point_doing,
   input  logic [7:0]                                   point_input_channel_sel_delay3,
   input  logic [7:0]                                   point_output_channel_sel_delay3,
   input  logic [DATA_WIDTH*OUTCHANNEL_PARALLELISM-1:0] outfeature,
   input  logic                                         point11_done,
   output logic                                         p2p_stall,
   output logic                                         err,
   p2p_if.master                                        dn
);

   localparam int unsigned OCP = OUTCHANNEL_PARALLELISM;
   localparam int unsigned ICP = INCHANNEL_PARALLELISM;
   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned WW  = DATA_WIDTH * OCP;

   state_e        state_q, state_d;
   logic [AW-1:0] group_q, group_d;
   logic          wb_q, rb_q, err_q;
   logic [1:0]    full_q, full_d;
   logic [7:0]    g_full, in_base, last_group;
   logic [8:0]    groups;
   logic          first, wr_ok, done_ok, stall, is_last, last_xfer;
   logic [WW-1:0] rdata0, rdata1, rd_word;

   assign g_full     = point_output_channel_sel_delay3 / 8'(OCP);
   assign in_base    = point_input_channel_sel_delay3 / 8'(ICP);
   assign first      = (input_channel < 8'(ICP)) || (in_base == 8'd0);
   assign groups     = ({1'b0, output_channel} + 9'(OCP - 1)) / 9'(OCP);
   assign last_group = (groups == 9'd0) ? 8'd0 : 8'(groups - 9'd1);

   assign stall     = full_q[wb_q];
   assign wr_ok     = point_doing && !stall && ({1'b0, g_full} < 9'(DEPTH));
   assign done_ok   = point11_done && !stall;
   assign is_last   = (8'(group_q) == last_group);
   assign last_xfer = (state_q == StStream) && dn.out_ready && is_last;
   assign rd_word   = rb_q ? rdata1 : rdata0;
   assign p2p_stall = stall;
   assign err       = err_q;

   p2p_bank #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .LANES(OCP)) u_bank0 (
      .clk   (clk),
      .we    (wr_ok && !wb_q),
      .accum (!first),
      .waddr (g_full[AW-1:0]),
      .wdata (outfeature),
      .raddr (group_q),
      .rdata (rdata0)
   );

   p2p_bank #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .LANES(OCP)) u_bank1 (
      .clk   (clk),
      .we    (wr_ok && wb_q),
      .accum (!first),
      .waddr (g_full[AW-1:0]),
      .wdata (outfeature),
      .raddr (group_q),
      .rdata (rdata1)
   );

   // A completion on wb and a final drain on rb touch different flags and both apply.
   always_comb begin
      full_d = full_q;
      if (done_ok) full_d[wb_q] = 1'b1;
      if (last_xfer) full_d[rb_q] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_q   <= 1'b0;
         rb_q   <= 1'b0;
         full_q <= 2'b00;
         err_q  <= 1'b0;
      end else begin
         full_q <= full_d;
         if (done_ok) wb_q <= !wb_q;
         if (last_xfer) rb_q <= !rb_q;
         if (stall && (point_doing || point11_done)) err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         group_q <= '0;
      end else begin
         state_q <= state_d;
         group_q <= group_d;
      end
   end

   always_comb begin
      state_d = state_q;
      group_d = group_q;
      unique case (state_q)
         StIdle: begin
            if (full_q[rb_q]) begin
               state_d = StStream;
               group_d = '0;
            end
         end
         StStream: begin
            if (dn.out_ready) begin
               if (is_last) state_d = StIdle;
               else         group_d = group_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      dn.out_valid       = 1'b0;
      dn.out_data        = '0;
      dn.out_channel_sel = '0;
      dn.out_last        = 1'b0;
      if (state_q == StStream) begin
         dn.out_valid       = 1'b1;
         dn.out_data        = rd_word;
         dn.out_channel_sel = 8'(group_q) * 8'(OCP);
         dn.out_last        = is_last;
`ifdef P2P_RELU_EN
         for (int i = 0; i < int'(OCP); i++) begin
            if (rd_word[i*DATA_WIDTH + DATA_WIDTH - 1]) dn.out_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
         end
`endif
      end
   end

endmodule
